// File: rtl/scma_host_sequencer.sv
// Host-side command sequencer for the SCMA IO block.
// Converts a valid/ready command stream into registered a_in/data_in bus cycles.
// Output reads are returned on a valid/ready response port.
// IO address map: 0x0100+row array rows, 0x0020+slot input buffer,
// 0x0030+slot registers, 0x0200+(slot<<4) outputs, 0x7800 idle.
module scma_host_sequencer #(
    parameter int DATA_IN_WIDTH  = 36,
    parameter int DATA_OUT_WIDTH = 32,
    parameter int ADDR_IN_WIDTH  = 15,
    parameter int RD_HOLD        = 1,
    parameter int WAIT_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd_op,
    input  logic [7:0]                cmd_addr,
    input  logic [DATA_IN_WIDTH-1:0]  cmd_data,
    output logic [ADDR_IN_WIDTH-1:0]  a_in,
    output logic [DATA_IN_WIDTH-1:0]  data_in,
    input  logic [DATA_OUT_WIDTH-1:0] data_out,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [3:0]                rsp_addr,
    output logic [DATA_OUT_WIDTH-1:0] rsp_data,
    output logic                      busy,
    output logic                      err
);

    localparam logic [ADDR_IN_WIDTH-1:0] IDLE_ADDR = ADDR_IN_WIDTH'(15'h7800);
    localparam int HOLD_W = (RD_HOLD > 1) ? $clog2(RD_HOLD) : 1;

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_WR_ARRAY = 3'd1;
    localparam logic [2:0] OP_WR_INPUT = 3'd2;
    localparam logic [2:0] OP_WR_REG   = 3'd3;
    localparam logic [2:0] OP_RD_OUT   = 3'd4;
    localparam logic [2:0] OP_WAIT     = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_RD, S_RSP, S_WAIT
    } state_t;

    state_t                    state, state_nx;
    logic [ADDR_IN_WIDTH-1:0]  a_in_nx;
    logic [DATA_IN_WIDTH-1:0]  data_in_nx;
    logic                      rsp_valid_nx;
    logic [3:0]                rsp_addr_nx;
    logic [DATA_OUT_WIDTH-1:0] rsp_data_nx;
    logic                      err_nx;
    logic [WAIT_WIDTH-1:0]     wait_cnt, wait_cnt_nx;
    logic [HOLD_W-1:0]         hold_cnt, hold_cnt_nx;
    logic [3:0]                rd_slot, rd_slot_nx;
    logic                      accept;

    assign cmd_ready = (state == S_IDLE) || (state == S_ISSUE);
    assign busy      = (state != S_IDLE);
    assign accept    = cmd_valid & cmd_ready;

    // Next-state and next-register values for the whole sequencer.
    always_comb begin
        state_nx     = state;
        a_in_nx      = a_in;
        data_in_nx   = data_in;
        rsp_valid_nx = rsp_valid;
        rsp_addr_nx  = rsp_addr;
        rsp_data_nx  = rsp_data;
        err_nx       = 1'b0;
        wait_cnt_nx  = wait_cnt;
        hold_cnt_nx  = hold_cnt;
        rd_slot_nx   = rd_slot;
        case (state)
            S_IDLE, S_ISSUE: begin
                // Unless a new command is encoded, the bus drops back to idle.
                a_in_nx  = IDLE_ADDR;
                state_nx = S_IDLE;
                if (accept) begin
                    case (cmd_op)
                        OP_NOP: ;
                        OP_WR_ARRAY: begin
                            a_in_nx    = ADDR_IN_WIDTH'({7'b0000001, cmd_addr});
                            data_in_nx = {{(DATA_IN_WIDTH-32){1'b1}}, ~cmd_data[31:0]};
                            state_nx   = S_ISSUE;
                        end
                        OP_WR_INPUT: begin
                            a_in_nx    = ADDR_IN_WIDTH'({11'h002, cmd_addr[3:0]});
                            data_in_nx = cmd_data;
                            state_nx   = S_ISSUE;
                        end
                        OP_WR_REG: begin
                            a_in_nx    = ADDR_IN_WIDTH'({11'h003, cmd_addr[3:0]});
                            data_in_nx = cmd_data;
                            state_nx   = S_ISSUE;
                        end
                        OP_RD_OUT: begin
                            a_in_nx     = ADDR_IN_WIDTH'({7'h02, cmd_addr[3:0], 4'h0});
                            rd_slot_nx  = cmd_addr[3:0];
                            hold_cnt_nx = HOLD_W'(RD_HOLD - 1);
                            state_nx    = S_RD;
                        end
                        OP_WAIT: begin
                            // A zero count skips the WAIT state entirely.
                            wait_cnt_nx = cmd_data[WAIT_WIDTH-1:0];
                            if (cmd_data[WAIT_WIDTH-1:0] != '0) state_nx = S_WAIT;
                        end
                        default: err_nx = 1'b1;
                    endcase
                end
            end
            S_RD: begin
                if (hold_cnt == '0) begin
                    rsp_data_nx  = data_out;
                    rsp_addr_nx  = rd_slot;
                    rsp_valid_nx = 1'b1;
                    a_in_nx      = IDLE_ADDR;
                    state_nx     = S_RSP;
                end else begin
                    hold_cnt_nx = hold_cnt - 1'b1;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_nx = 1'b0;
                    state_nx     = S_IDLE;
                end
            end
            S_WAIT: begin
                a_in_nx     = IDLE_ADDR;
                wait_cnt_nx = wait_cnt - 1'b1;
                if (wait_cnt <= WAIT_WIDTH'(1)) begin
                    wait_cnt_nx = '0;
                    state_nx    = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Bus, response and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_in      <= IDLE_ADDR;
            data_in   <= '0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
            err       <= 1'b0;
            wait_cnt  <= '0;
            hold_cnt  <= '0;
            rd_slot   <= '0;
        end else begin
            a_in      <= a_in_nx;
            data_in   <= data_in_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_addr  <= rsp_addr_nx;
            rsp_data  <= rsp_data_nx;
            err       <= err_nx;
            wait_cnt  <= wait_cnt_nx;
            hold_cnt  <= hold_cnt_nx;
            rd_slot   <= rd_slot_nx;
        end
    end

endmodule

// File: tb/tb_scma_host_sequencer.sv
// Directed self-checking bench for scma_host_sequencer.
module tb_scma_host_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_addr;
    logic [35:0] cmd_data;
    logic [14:0] a_in;
    logic [35:0] data_in;
    logic [31:0] data_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_addr;
    logic [31:0] rsp_data;
    logic        busy;
    logic        err;

    int n_chk  = 0;
    int n_pass = 0;

    scma_host_sequencer #(
        .DATA_IN_WIDTH(36), .DATA_OUT_WIDTH(32), .ADDR_IN_WIDTH(15),
        .RD_HOLD(1), .WAIT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .a_in(a_in), .data_in(data_in), .data_out(data_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
        .rsp_data(rsp_data), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [7:0] addr, input logic [35:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
    endtask

    logic [14:0] t3_addr [9];
    logic [31:0] hold_data;
    int          n;
    logic        bad;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = 8'd0; cmd_data = 36'd0;
        data_out = 32'd0; rsp_ready = 1'b0;
        step();
        chk("rst_a_in", a_in, 15'h7800);
        chk("rst_data_in", data_in, 36'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        step();

        // T2 array write
        drive(3'd1, 8'd128, 36'h076543210);
        chk("t2_ready", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
        chk("t2_a_in", a_in, 15'h0180);
        chk("t2_data_in", data_in, 36'hF89ABCDEF);
        chk("t2_busy", busy, 1'b1);
        step();
        chk("t2_a_in_idle", a_in, 15'h7800);
        chk("t2_data_keep", data_in, 36'hF89ABCDEF);
        chk("t2_busy_idle", busy, 1'b0);

        // T3 register write then eight back-to-back input writes
        t3_addr[0] = 15'h0030;
        for (int i = 1; i < 9; i++) t3_addr[i] = 15'h0020 + 15'(i - 1);
        for (int i = 0; i < 9; i++) begin
            if (i == 0) drive(3'd3, 8'd0, 36'h1);
            else        drive(3'd2, 8'(i - 1), 36'h0FFFFFFFF);
            chk($sformatf("t3_ready_%0d", i), cmd_ready, 1'b1);
            if (i > 0) chk($sformatf("t3_a_in_%0d", i - 1), a_in, t3_addr[i - 1]);
            if (i == 1) chk("t3_reg_data", data_in, 36'h1);
            step();
        end
        cmd_valid = 1'b0;
        chk("t3_a_in_8", a_in, t3_addr[8]);
        chk("t3_data_in", data_in, 36'h0FFFFFFFF);
        step();
        chk("t3_a_in_idle", a_in, 15'h7800);

        // T4 wait 31 then output read of slot 1 (upper address bits set, ignored)
        drive(3'd5, 8'd0, 36'd31);
        step();
        cmd_valid = 1'b0;
        n = 0; bad = 1'b0;
        while (!cmd_ready && n < 100) begin
            if (a_in !== 15'h7800) bad = 1'b1;
            n++;
            step();
        end
        chk("t4_wait_len", n, 31);
        chk("t4_wait_a_in", bad, 1'b0);
        data_out = 32'hCAFEF00D;
        drive(3'd4, 8'hF1, 36'd0);
        step();
        cmd_valid = 1'b0;
        chk("t4_rd_a_in", a_in, 15'h0210);
        chk("t4_rd_ready", cmd_ready, 1'b0);
        chk("t4_rd_rsp_valid", rsp_valid, 1'b0);
        step();
        chk("t4_rsp_valid", rsp_valid, 1'b1);
        chk("t4_rsp_addr", rsp_addr, 4'd1);
        chk("t4_rsp_data", rsp_data, 32'hCAFEF00D);
        chk("t4_rsp_a_in", a_in, 15'h7800);

        // T5 backpressure, with a competing command presented
        data_out = 32'h0;
        drive(3'd3, 8'd5, 36'h123);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_addr !== 4'd1 || rsp_data !== 32'hCAFEF00D ||
                cmd_ready !== 1'b0 || a_in !== 15'h7800) bad = 1'b1;
            step();
        end
        chk("t5_stable", bad, 1'b0);
        rsp_ready = 1'b1;
        chk("t5_release_ready", cmd_ready, 1'b0);
        step();
        rsp_ready = 1'b0;
        chk("t5_rsp_valid_low", rsp_valid, 1'b0);
        chk("t5_idle", busy, 1'b0);
        chk("t5_not_taken", a_in, 15'h7800);
        chk("t5_ready_again", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
        chk("t5_reg_a_in", a_in, 15'h0035);
        chk("t5_reg_data", data_in, 36'h123);
        step();

        // T6 illegal op, NOP, zero wait
        drive(3'd7, 8'd0, 36'd0);
        step();
        cmd_valid = 1'b0;
        chk("t6_err", err, 1'b1);
        chk("t6_a_in", a_in, 15'h7800);
        chk("t6_busy", busy, 1'b0);
        step();
        chk("t6_err_pulse", err, 1'b0);
        drive(3'd0, 8'd0, 36'd0);
        step();
        cmd_valid = 1'b0;
        chk("nop_a_in", a_in, 15'h7800);
        chk("nop_err", err, 1'b0);
        chk("nop_busy", busy, 1'b0);
        drive(3'd5, 8'd0, 36'd0);
        step();
        cmd_valid = 1'b0;
        chk("wait0_ready", cmd_ready, 1'b1);
        chk("wait0_busy", busy, 1'b0);

        // T1 asynchronous reset in the middle of a read
        drive(3'd4, 8'd2, 36'd0);
        data_out = 32'h12345678;
        step();
        cmd_valid = 1'b0;
        chk("t1_rd_a_in", a_in, 15'h0220);
        chk("t1_rd_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t1_async_a_in", a_in, 15'h7800);
        chk("t1_async_busy", busy, 1'b0);
        chk("t1_async_rsp_valid", rsp_valid, 1'b0);
        step();
        rst = 1'b0;
        step();
        chk("t1_post_rsp_valid", rsp_valid, 1'b0);
        chk("t1_post_a_in", a_in, 15'h7800);
        chk("t1_post_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
